// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU input sequencer.
package alu_pkg;

    // Sequencer states; encodings are fixed because state_out is displayed.
    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // ALU opcodes carried on ctrl_out.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Bit positions inside the {v,c,n,z} flag vector.
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Operation counter step; wraps naturally at 8 bits.
    function automatic logic [7:0] count_next(input logic [7:0] cnt);
        return cnt + 8'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q_r;

    // Remember the previous level; only a full reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_r <= 1'b0;
        end else begin
            d_q_r <= d;
        end
    end

    assign pulse = d & ~d_q_r;

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps operand A, operand B and opcode off a shared bus into a downstream ALU,
// then captures the ALU result and flags one cycle after the opcode is loaded.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [1:0]   ctrl_out,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic [2:0]   state_out,
    output logic         done,
    output logic [7:0]   op_count
);

    state_t       state_r;
    state_t       state_next_s;
    logic         load_pulse_s;
    logic         load_a_s;
    logic         load_b_s;
    logic         load_op_s;
    logic         capture_s;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic [1:0]   ctrl_r;
    logic [N-1:0] result_r;
    logic [3:0]   flags_r;
    logic         done_r;
    logic [7:0]   op_count_r;

    edge_detect u_load_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (load),
        .pulse (load_pulse_s)
    );

    // Next-state and register-enable decode; clear overrides every transition.
    always_comb begin
        state_next_s = state_r;
        load_a_s     = 1'b0;
        load_b_s     = 1'b0;
        load_op_s    = 1'b0;
        capture_s    = 1'b0;
        if (clear) begin
            state_next_s = LOAD_A;
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (load_pulse_s) begin
                        load_a_s     = 1'b1;
                        state_next_s = LOAD_B;
                    end else begin
                        state_next_s = LOAD_A;
                    end
                end
                LOAD_B: begin
                    if (load_pulse_s) begin
                        load_b_s     = 1'b1;
                        state_next_s = LOAD_OP;
                    end else begin
                        state_next_s = LOAD_B;
                    end
                end
                LOAD_OP: begin
                    if (load_pulse_s) begin
                        load_op_s    = 1'b1;
                        state_next_s = EXEC;
                    end else begin
                        state_next_s = LOAD_OP;
                    end
                end
                EXEC: begin
                    capture_s    = 1'b1;
                    state_next_s = SHOW;
                end
                SHOW: begin
                    if (load_pulse_s) begin
                        load_a_s     = 1'b1;
                        state_next_s = LOAD_B;
                    end else begin
                        state_next_s = SHOW;
                    end
                end
                default: begin
                    state_next_s = LOAD_A;
                end
            endcase
        end
    end

    // State, operand, result and counter registers; clear spares op_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOAD_A;
            a_r        <= '0;
            b_r        <= '0;
            ctrl_r     <= 2'b00;
            result_r   <= '0;
            flags_r    <= 4'b0000;
            done_r     <= 1'b0;
            op_count_r <= 8'd0;
        end else if (clear) begin
            state_r    <= LOAD_A;
            a_r        <= '0;
            b_r        <= '0;
            ctrl_r     <= 2'b00;
            result_r   <= '0;
            flags_r    <= 4'b0000;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == SHOW);
            if (load_a_s) begin
                a_r <= data_in;
            end
            if (load_b_s) begin
                b_r <= data_in;
            end
            if (load_op_s) begin
                ctrl_r <= data_in[1:0];
            end
            if (capture_s) begin
                result_r   <= alu_result;
                flags_r    <= alu_flags;
                op_count_r <= count_next(op_count_r);
            end
        end
    end

    assign a_out     = a_r;
    assign b_out     = b_r;
    assign ctrl_out  = ctrl_r;
    assign result_q  = result_r;
    assign flags_q   = flags_r;
    assign state_out = state_r;
    assign done      = done_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer with a 4-bit ALU attached.
module tb_alu_input_sequencer;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] data_in;
    logic         load;
    logic         clear;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [N-1:0] a_out;
    logic [N-1:0] b_out;
    logic [1:0]   ctrl_out;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic [2:0]   state_out;
    logic         done;
    logic [7:0]   op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers).
    int m_state;  // 0..4 = LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW
    int m_a, m_b, m_op, m_res, m_flags, m_cnt;
    int m_prev_load;

    alu_input_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .clear      (clear),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .a_out      (a_out),
        .b_out      (b_out),
        .ctrl_out   (ctrl_out),
        .result_q   (result_q),
        .flags_q    (flags_q),
        .state_out  (state_out),
        .done       (done),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU computed with integer arithmetic; returns {v,c,n,z} * 16 + result.
    function automatic int alu_calc(input int a, input int b, input int op);
        int s, r, v, c, n, z;
        v = 0; c = 0;
        case (op)
            0: begin
                s = a + b; r = s % 16; c = (s > 15) ? 1 : 0;
                v = ((a >= 8) == (b >= 8) && (r >= 8) != (a >= 8)) ? 1 : 0;
            end
            1: begin
                s = a + (15 - b) + 1; r = s % 16; c = (s > 15) ? 1 : 0;
                v = ((a >= 8) != (b >= 8) && (r >= 8) != (a >= 8)) ? 1 : 0;
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        n = (r >= 8) ? 1 : 0;
        z = (r == 0) ? 1 : 0;
        return (v * 8 + c * 4 + n * 2 + z) * 16 + r;
    endfunction

    // Downstream ALU attached to the sequencer outputs.
    always_comb begin
        int t;
        t = alu_calc(int'(a_out), int'(b_out), int'(ctrl_out));
        alu_result = t[3:0];
        alu_flags  = t[7:4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int pulse, t;
        if (rst) begin
            m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
            m_cnt = 0; m_prev_load = 0;
        end else begin
            pulse = (load && m_prev_load == 0) ? 1 : 0;
            m_prev_load = load ? 1 : 0;
            if (clear) begin
                m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
            end else if (m_state == 0 || m_state == 4) begin
                if (pulse == 1) begin m_a = int'(data_in); m_state = 1; end
            end else if (m_state == 1) begin
                if (pulse == 1) begin m_b = int'(data_in); m_state = 2; end
            end else if (m_state == 2) begin
                if (pulse == 1) begin m_op = int'(data_in) % 4; m_state = 3; end
            end else begin
                t = alu_calc(m_a, m_b, m_op);
                m_res = t % 16; m_flags = t / 16;
                m_cnt = (m_cnt + 1) % 256;
                m_state = 4;
            end
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state_out), 32'(m_state));
        check("a_out", 32'(a_out), 32'(m_a));
        check("b_out", 32'(b_out), 32'(m_b));
        check("ctrl", 32'(ctrl_out), 32'(m_op));
        check("result", 32'(result_q), 32'(m_res));
        check("flags", 32'(flags_q), 32'(m_flags));
        check("done", 32'(done), (m_state == 4) ? 32'd1 : 32'd0);
        check("op_count", 32'(op_count), 32'(m_cnt));
    endtask

    task automatic step(input logic r, input logic l, input logic c, input logic [3:0] d);
        rst = r; load = l; clear = c; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic load_val(input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, d);
        step(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        load_val(a);
        load_val(b);
        load_val(op);
    endtask

    initial begin
        int start_cnt;
        rst = 1'b1; load = 1'b0; clear = 1'b0; data_in = 4'h0;
        m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
        m_cnt = 0; m_prev_load = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'hF);
        check("reset_state", 32'(state_out), 32'd0);
        check("reset_count", 32'(op_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // Add: 5 + 3
        do_op(4'b0101, 4'b0011, 4'b0000);
        check("add_result", 32'(result_q), 32'b1000);
        check("add_flags", 32'(flags_q), 32'b1010);
        check("add_done", 32'(done), 32'd1);
        check("add_count", 32'(op_count), 32'd1);

        // Sub: 5 - 5 (starts from SHOW)
        do_op(4'b0101, 4'b0101, 4'b1101);
        check("sub_result", 32'(result_q), 32'b0000);
        check("sub_flags", 32'(flags_q), 32'b0101);
        check("sub_ctrl", 32'(ctrl_out), 32'b01);

        // And: 1100 & 1010
        do_op(4'b1100, 4'b1010, 4'b0010);
        check("and_result", 32'(result_q), 32'b1000);
        check("and_flags", 32'(flags_q), 32'b0010);

        // Held load: one advance only
        step(1'b0, 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'h9);
        check("held_state", 32'(state_out), 32'd1);
        check("held_a", 32'(a_out), 32'h9);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // Clear in LOAD_OP while load pulses
        load_val(4'h6);
        check("pre_clear_state", 32'(state_out), 32'd2);
        start_cnt = int'(op_count);
        step(1'b0, 1'b1, 1'b1, 4'h3);
        check("clear_state", 32'(state_out), 32'd0);
        check("clear_a", 32'(a_out), 32'd0);
        check("clear_b", 32'(b_out), 32'd0);
        check("clear_result", 32'(result_q), 32'd0);
        check("clear_count", 32'(op_count), 32'(start_cnt));
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // 256 operations from a fresh reset wrap op_count to 0
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 256; i++)
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        check("wrap_count", 32'(op_count), 32'd0);

        // Reset during EXEC: no capture
        load_val(4'h7);
        load_val(4'h2);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        check("exec_state", 32'(state_out), 32'd3);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        check("rst_exec_state", 32'(state_out), 32'd0);
        check("rst_exec_result", 32'(result_q), 32'd0);
        check("rst_exec_count", 32'(op_count), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
